// File: rtl/data_mem_ctrl.sv
// Word-wide data memory responder for LW/SW: internal synchronous RAM with
// configurable wait states, pipeline stall, registered read data and error pulse.
module data_mem_ctrl #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [31:0]           addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  busy,
    output logic                  mem_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic                    is_read_r;
    logic [ADDR_WIDTH-1:0]   idx_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [3:0]              cnt_r;
    logic                    valid_req_s;
    logic                    reject_s;
    logic                    access_s;
    logic                    unused_addr_s;

    logic [DATA_WIDTH-1:0]   ram [2**ADDR_WIDTH];

    assign valid_req_s   = (mem_read ^ mem_write) && (addr[1:0] == 2'b00);
    assign reject_s      = (mem_read | mem_write) && !valid_req_s;
    assign access_s      = (state_r == WAIT) && (cnt_r == 4'd0);
    // Upper address bits alias by design.
    assign unused_addr_s = ^addr[31:ADDR_WIDTH+2];

    // Next-state and stall decode.
    always_comb begin
        state_s = state_r;
        busy    = 1'b0;
        case (state_r)
            IDLE: begin
                if (valid_req_s) begin
                    busy    = 1'b1;
                    state_s = WAIT;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (cnt_r == 4'd0) begin
                    state_s = DONE;
                end else begin
                    state_s = WAIT;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Control state, request latch, wait counter and registered responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            is_read_r <= 1'b0;
            idx_r     <= '0;
            wdata_r   <= '0;
            cnt_r     <= 4'd0;
            rdata     <= '0;
            rvalid    <= 1'b0;
            mem_err   <= 1'b0;
        end else begin
            state_r <= state_s;
            rvalid  <= access_s && is_read_r;
            mem_err <= (state_r == IDLE) && reject_s;
            if ((state_r == IDLE) && valid_req_s) begin
                is_read_r <= mem_read;
                idx_r     <= addr[ADDR_WIDTH+1:2];
                wdata_r   <= wdata;
                cnt_r     <= 4'(WAIT_STATES);
            end else if ((state_r == WAIT) && (cnt_r != 4'd0)) begin
                cnt_r <= cnt_r - 4'd1;
            end
            if (access_s && is_read_r) begin
                rdata <= ram[idx_r];
            end
        end
    end

    // RAM write port; contents survive reset, but reset at the access edge drops the store.
    always_ff @(posedge clk) begin
        if (!rst && access_s && !is_read_r) begin
            ram[idx_r] <= wdata_r;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: randomized loads/stores against a
// word-array reference model, plus latency, reject, aliasing and reset scenarios.
module tb_data_mem_ctrl;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int WS = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_read;
    logic          mem_write;
    logic [31:0]   addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata, rdata0;
    logic          rvalid, busy, mem_err;
    logic          rvalid0, busy0, mem_err0;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DW-1:0] model_mem [int];
    logic [DW-1:0] exp_rdata;

    data_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .rvalid(rvalid),
        .busy(busy), .mem_err(mem_err)
    );

    // Zero-wait-state instance sharing the same request bus.
    data_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .rdata(rdata0), .rvalid(rvalid0),
        .busy(busy0), .mem_err(mem_err0)
    );

    always #5 clk = ~clk;

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) & ((32'd1 << AW) - 32'd1));
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One access presented for a single cycle from IDLE; checks the whole response window.
    task automatic access(input bit rd, input logic [31:0] a, input logic [DW-1:0] wd,
                          input bit chk0);
        logic [2:0]    exp_flags;
        logic [DW-1:0] rd_val;
        int            idx;
        idx       = widx(a);
        mem_read  = rd;
        mem_write = !rd;
        addr      = a;
        wdata     = wd;
        rd_val    = model_mem.exists(idx) ? model_mem[idx] : 'x;
        for (int c = 0; c < WS + 3; c++) begin
            @(negedge clk);
            exp_flags = {(c <= WS + 1), (c == WS + 2) && rd, 1'b0};
            tests_run++;
            if ({busy, rvalid, mem_err} !== exp_flags) begin
                tests_failed++;
                $display("FAIL access_flags c=%0d rd=%0d addr=%h got %b exp %b",
                         c, rd, a, {busy, rvalid, mem_err}, exp_flags);
            end
            if (c == WS + 2) begin
                if (rd) exp_rdata = rd_val;
                tests_run++;
                if (rdata !== exp_rdata) begin
                    tests_failed++;
                    $display("FAIL access_rdata addr=%h got %h exp %h", a, rdata, exp_rdata);
                end
            end
            if (chk0 && c <= 2) begin
                tests_run++;
                if ({busy0, rvalid0, mem_err0} !== {(c <= 1), (c == 2) && rd, 1'b0}) begin
                    tests_failed++;
                    $display("FAIL ws0_flags c=%0d got %b exp %b", c,
                             {busy0, rvalid0, mem_err0}, {(c <= 1), (c == 2) && rd, 1'b0});
                end
                if (c == 2 && rd) begin
                    tests_run++;
                    if (rdata0 !== rd_val) begin
                        tests_failed++;
                        $display("FAIL ws0_rdata got %h exp %h", rdata0, rd_val);
                    end
                end
            end
            next_cycle();
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
        if (!rd) model_mem[idx] = wd;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
        repeat (2) next_cycle();
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({busy, rvalid, mem_err, rdata} !== {3'b000, {DW{1'b0}}}) begin
            tests_failed++;
            $display("FAIL reset_state got %b/%h exp 000/0", {busy, rvalid, mem_err}, rdata);
        end
        exp_rdata = '0;
        next_cycle();
    endtask

    task automatic test_write_read();
        access(1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        access(1'b1, 32'h10, 32'h0, 1'b0);
    endtask

    task automatic test_ws0_latency();
        access(1'b1, 32'h10, 32'h0, 1'b1);
    endtask

    task automatic test_reject();
        logic [2:0] exp_flags;
        for (int p = 0; p < 2; p++) begin
            mem_read  = 1'b1;
            mem_write = (p == 1);
            addr      = (p == 0) ? 32'h13 : 32'h10;
            @(negedge clk);
            tests_run++;
            if ({busy, rvalid, mem_err} !== 3'b000) begin
                tests_failed++;
                $display("FAIL reject_t0 p=%0d got %b exp 000", p, {busy, rvalid, mem_err});
            end
            next_cycle();
            mem_read = 1'b0; mem_write = 1'b0;
            @(negedge clk);
            tests_run++;
            if ({busy, rvalid, mem_err} !== 3'b001) begin
                tests_failed++;
                $display("FAIL reject_t1 p=%0d got %b exp 001", p, {busy, rvalid, mem_err});
            end
            next_cycle();
            @(negedge clk);
            tests_run++;
            if ({busy, rvalid, mem_err, rdata} !== {3'b000, exp_rdata}) begin
                tests_failed++;
                $display("FAIL reject_t2 p=%0d got %b/%h exp 000/%h", p,
                         {busy, rvalid, mem_err}, rdata, exp_rdata);
            end
            next_cycle();
        end
        // Rejects back to back: one error pulse per request.
        for (int c = 0; c < 5; c++) begin
            mem_write = (c < 3);
            addr      = 32'h22;
            @(negedge clk);
            exp_flags = {2'b00, (c >= 1) && (c <= 3)};
            tests_run++;
            if ({busy, rvalid, mem_err} !== exp_flags) begin
                tests_failed++;
                $display("FAIL reject_b2b c=%0d got %b exp %b", c, {busy, rvalid, mem_err}, exp_flags);
            end
            next_cycle();
        end
        mem_write = 1'b0;
    endtask

    task automatic test_alias();
        access(1'b0, 32'h000, 32'h1, 1'b0);
        access(1'b1, 32'h400, 32'h0, 1'b0);
    endtask

    task automatic test_held_read();
        logic [2:0] exp_flags;
        int         ph;
        mem_read = 1'b1;
        addr     = 32'h10;
        for (int c = 0; c < 3 * (WS + 3); c++) begin
            ph = c % (WS + 3);
            @(negedge clk);
            exp_flags = {(ph <= WS + 1), (ph == WS + 2), 1'b0};
            tests_run++;
            if ({busy, rvalid, mem_err} !== exp_flags) begin
                tests_failed++;
                $display("FAIL held_flags c=%0d got %b exp %b", c, {busy, rvalid, mem_err}, exp_flags);
            end
            if (ph == WS + 2) begin
                exp_rdata = model_mem[widx(32'h10)];
                tests_run++;
                if (rdata !== exp_rdata) begin
                    tests_failed++;
                    $display("FAIL held_rdata got %h exp %h", rdata, exp_rdata);
                end
            end
            next_cycle();
        end
        mem_read = 1'b0;
        next_cycle();
    endtask

    task automatic test_random();
        logic [31:0] a;
        int          keys [$];
        for (int i = 0; i < 24; i++) begin
            a = $urandom();
            a[1:0] = 2'b00;
            keys = {};
            foreach (model_mem[k]) keys.push_back(k);
            if ($urandom_range(1) == 1 && keys.size() > 0) begin
                a[AW+1:2] = AW'(keys[$urandom_range(keys.size() - 1)]);
                access(1'b1, a, 32'h0, 1'b0);
            end else begin
                access(1'b0, a, $urandom(), 1'b0);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        access(1'b0, 32'h20, 32'hAA, 1'b0);
        mem_write = 1'b1;
        addr      = 32'h20;
        wdata     = 32'h55;
        for (int c = 0; c <= WS + 1; c++) begin
            if (c == WS + 1) rst = 1'b1;
            @(negedge clk);
            tests_run++;
            if (busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL rstmid_busy c=%0d got %b exp 1", c, busy);
            end
            next_cycle();
            mem_write = 1'b0;
        end
        rst = 1'b0;
        exp_rdata = '0;
        @(negedge clk);
        tests_run++;
        if ({busy, rvalid, mem_err, rdata} !== {3'b000, {DW{1'b0}}}) begin
            tests_failed++;
            $display("FAIL rstmid_after got %b/%h exp 000/0", {busy, rvalid, mem_err}, rdata);
        end
        next_cycle();
        access(1'b1, 32'h20, 32'h0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_ws0_latency();
        test_reject();
        test_alias();
        test_held_read();
        test_random();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
